// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
//   N_REQ       : number of requesters sharing the downstream port
//   SEL_W       : width of the owner index / mux select
//   arb_state_e : arbiter FSM state encoding
package mux4_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker. Starting from the requester after the last
// winner, returns the index of the first active request.
//   req  [3:0] : request vector, bit i = requester i
//   last [1:0] : index of the most recent winner
//   any        : at least one request is active
//   idx  [1:0] : chosen requester (only meaningful when any = 1)
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan offsets from farthest to nearest; the nearest hit is written
  // last, so it wins. Offset 4 wraps to 'last' itself, the lowest priority.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter granting one of four requesters access to a shared
// 32-bit downstream port. Drives the 4:1 operand-mux select, owns the
// mem_req/mem_ack handshake, and aborts a grant after TIMEOUT cycles
// without acknowledge.
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-requester request, held until done[i] or err
//   mem_ack   : single-cycle completion from downstream
//   mem_req   : high throughout GRANT
//   sel       : binary owner index for the operand mux
//   gnt       : one-hot grant, high throughout GRANT
//   done      : one-cycle one-hot completion pulse
//   err       : one-cycle timeout-abort pulse, err_id = aborted owner
//   busy      : high in GRANT and RELEASE
//
// state   | meaning
// IDLE    | no owner; pick next requester round-robin
// GRANT   | owner holds the port, waiting for mem_ack or timeout
// RELEASE | one-cycle gap; done/err pulse visible, grant dropped
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             err,
  output logic [SEL_W-1:0] err_id,
  output logic             busy
);

  arb_state_e       state_q;
  logic [SEL_W-1:0] last_q;
  logic [SEL_W-1:0] sel_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic [SEL_W-1:0] err_id_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mem_req_q;
  logic             err_q;
  logic             busy_q;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;

  rr_pick4 u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign cnt_d = cnt_q + CNT_W'(1);

  // sel_q doubles as the owner register: it is loaded on grant and held
  // through RELEASE and IDLE so the operand mux never toggles needlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= SEL_W'(N_REQ - 1);
      sel_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      err_id_q  <= '0;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            sel_q     <= pick_idx;
            gnt_q     <= N_REQ'(1) << pick_idx;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= GRANT;
          end
        end
        GRANT: begin
          // Acknowledge is checked before the watchdog so a coincident
          // ack completes the transaction instead of aborting it.
          if (mem_ack) begin
            done_q    <= N_REQ'(1) << sel_q;
            last_q    <= sel_q;
            gnt_q     <= '0;
            mem_req_q <= 1'b0;
            state_q   <= RELEASE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_q     <= 1'b1;
            err_id_q  <= sel_q;
            last_q    <= sel_q;
            gnt_q     <= '0;
            mem_req_q <= 1'b0;
            state_q   <= RELEASE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RELEASE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q     <= '0;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign mem_req = mem_req_q;
  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign err_id  = err_id_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mem_ack;
  logic       mem_req;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       err;
  logic [1:0] err_id;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_grant_cyc;

  mux4_rr_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .sel     (sel),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .err_id  (err_id),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant from IDLE, ack after 'extra' further GRANT cycles, then RELEASE and IDLE.
  task automatic txn(input string tag, input logic [3:0] r, input int exp_idx, input int extra);
    logic [3:0] oh;
    oh  = 4'b0001 << exp_idx;
    req = r;
    tick();
    last_grant_cyc = cyc;
    chk({tag, ".gnt"},     32'(gnt),     32'(oh));
    chk({tag, ".sel"},     32'(sel),     32'(exp_idx));
    chk({tag, ".mem_req"}, 32'(mem_req), 32'd1);
    repeat (extra) tick();
    chk({tag, ".gnt_hold"}, 32'(gnt), 32'(oh));
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk({tag, ".done"},    32'(done),    32'(oh));
    chk({tag, ".rel_gnt"}, 32'(gnt),     32'd0);
    chk({tag, ".rel_err"}, 32'(err),     32'd0);
    chk({tag, ".rel_busy"},32'(busy),    32'd1);
    tick();
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ".idle_sel"},  32'(sel),  32'(exp_idx));
  endtask

  initial begin
    int prev;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req = 4'b0000; mem_ack = 1'b0;
    tick();
    tick();
    chk("rst.gnt",     32'(gnt),     32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.done",    32'(done),    32'd0);
    chk("rst.err",     32'(err),     32'd0);
    chk("rst.err_id",  32'(err_id),  32'd0);
    chk("rst.sel",     32'(sel),     32'd0);
    chk("rst.busy",    32'(busy),    32'd0);
    rst = 1'b0;

    // Basic: requester 2, ack on 3rd GRANT cycle
    txn("basic", 4'b0100, 2, 2);
    req = 4'b0000;
    tick();
    chk("basic.idle_nogrant", 32'(gnt), 32'd0);

    // Round robin from reset: 0,1,2,3,0, grants 3 cycles apart
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev = -1;
    for (int i = 0; i < 5; i++) begin
      txn($sformatf("rr%0d", i), 4'b1111, order[i], 0);
      if (prev >= 0) chk($sformatf("rr%0d.spacing", i), 32'(last_grant_cyc - prev), 32'd3);
      prev = last_grant_cyc;
    end

    // Rotation: requester 1 wins, then 0011 -> 0, then 0011 -> 1
    txn("rot_a", 4'b0010, 1, 0);
    txn("rot_b", 4'b0011, 0, 0);
    txn("rot_c", 4'b0011, 1, 0);

    // Timeout on requester 3, late ack in RELEASE ignored
    req = 4'b1000;
    tick();
    chk("to.gnt", 32'(gnt), 32'b1000);
    tick(); tick(); tick();
    chk("to.c4_mem_req", 32'(mem_req), 32'd1);
    chk("to.c4_err",     32'(err),     32'd0);
    tick();
    chk("to.err",    32'(err),    32'd1);
    chk("to.err_id", 32'(err_id), 32'd3);
    chk("to.done",   32'(done),   32'd0);
    chk("to.gnt0",   32'(gnt),    32'd0);
    mem_ack = 1'b1;
    req = 4'b0000;
    tick();
    mem_ack = 1'b0;
    chk("to.late_done", 32'(done), 32'd0);
    chk("to.late_err",  32'(err),  32'd0);
    chk("to.late_busy", 32'(busy), 32'd0);
    tick();
    chk("to.idle_gnt", 32'(gnt), 32'd0);

    // Ack on the 4th GRANT cycle collides with the timeout: ack wins
    txn("coll", 4'b0001, 0, 3);
    req = 4'b0000;

    // Reset mid-GRANT of requester 2
    req = 4'b0100;
    tick();
    chk("rmid.gnt", 32'(gnt), 32'b0100);
    tick();
    rst = 1'b1;
    req = 4'b0101;
    tick();
    chk("rmid.gnt0",    32'(gnt),     32'd0);
    chk("rmid.mem_req", 32'(mem_req), 32'd0);
    chk("rmid.done",    32'(done),    32'd0);
    chk("rmid.err",     32'(err),     32'd0);
    chk("rmid.busy",    32'(busy),    32'd0);
    rst = 1'b0;
    txn("rmid_after", 4'b0101, 0, 0);
    req = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
